muldiv: RTL
===========

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; iteration count equals DATA_WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin operation; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  operation: 0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU.
REQ-006 SHALL have ports a, b  input  DATA_WIDTH  operands (a=multiplicand/dividend, b=multiplier/divisor), captured at accept.
REQ-007 SHALL have ports hi_we, lo_we  input  1  write strobes for HI/LO (MTHI/MTLO).
REQ-008 SHALL have port wdata  input  DATA_WIDTH  data for hi_we/lo_we.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-011 SHALL have ports hi, lo  output  DATA_WIDTH  architectural HI/LO registers (registered outputs).

Function
REQ-012 SHALL implement states IDLE and RUN; IDLE->RUN on start=1 at edge E0; RUN->IDLE at edge E(DATA_WIDTH).
REQ-013 SHALL capture op, a, b at E0 and hold busy=1 from E0 through E(DATA_WIDTH), i.e. exactly DATA_WIDTH cycles.
REQ-014 SHALL process one quotient/product bit per cycle (shift-add multiply, restoring divide) on operand magnitudes.
REQ-015 SHALL load final hi/lo at E(DATA_WIDTH), including sign correction, and assert done for the single following cycle with busy=0.
REQ-016 Multiply SHALL produce the full 2*DATA_WIDTH product: hi=upper half, lo=lower half; MULT two's-complement, MULTU unsigned.
REQ-017 Divide SHALL produce lo=quotient, hi=remainder; DIV truncates toward zero, remainder takes dividend's sign.
REQ-018 Divide by zero SHALL yield lo=all ones, hi=a (both DIV and DIVU), same latency.
REQ-019 DIV of most-negative value by -1 SHALL yield lo=most-negative value, hi=0.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 hi_we/lo_we while busy=1 SHALL be ignored; hi/lo SHALL not change during RUN except at E(DATA_WIDTH).
REQ-022 hi_we/lo_we while busy=0 SHALL update the register at the next edge; both strobes together update both with wdata.
REQ-023 start with hi_we or lo_we in the same idle cycle: the write SHALL take effect, and the operation result SHALL later overwrite both.
REQ-024 start in the done cycle SHALL be accepted (back-to-back; done and new busy rise coincide).
REQ-025 hi and lo SHALL hold their values indefinitely in IDLE absent writes.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, clearing iteration counter and datapath.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse and no hi/lo result load.
REQ-028 After rst_n deasserts, first start SHALL be accepted on the next rising edge.

Verification
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 32 busy cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 start asserted at cycles 5 and 10 of a run with differing operands, plus hi_we=1 wdata=0x1234 mid-run -> only first op's result, hi not 0x1234.
REQ-033 rst_n pulsed low at cycle 16 of DIVU -> busy=0, hi=lo=0 immediately, no done; fresh MULTU 6*7 afterwards -> lo=42, hi=0.
REQ-034 start held high continuously with MULTU 2*3 -> done every 33 cycles, lo=6, busy low only in done cycles' preceding edge boundary as per REQ-024.

Source files
------------

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One product or quotient bit per cycle over operand magnitudes; signs are fixed up on the final edge.
module muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_next;
    logic            accept, finish;
    logic [CW-1:0]   count;
    logic [1:0]      op_q;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    upper, lower;
    logic [W-1:0]    step_upper, step_lower;
    logic [W-1:0]    res_hi, res_lo;
    logic            is_div, is_signed, neg_a, neg_b;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum, shifted, diff;
    logic [2*W-1:0]  prod, prod_fix;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: if (count == CW'(DATA_WIDTH - 1)) begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign neg_a     = is_signed & a_q[W-1];
    assign neg_b     = is_signed & b_q[W-1];
    assign mag_a     = magnitude(a_q, is_signed);
    assign mag_b     = magnitude(b_q, is_signed);

    // Multiply: upper accumulates, lower holds the shrinking multiplier and
    // collects low product bits. Divide: upper is the partial remainder,
    // lower shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum    = {1'b0, upper} + (lower[0] ? {1'b0, mag_a} : '0);
        shifted    = {upper, lower[W-1]};
        diff       = shifted - {1'b0, mag_b};
        step_upper = upper;
        step_lower = lower;
        if (!is_div) begin
            step_upper = mul_sum[W:1];
            step_lower = {mul_sum[0], lower[W-1:1]};
        end else if (!diff[W]) begin
            step_upper = diff[W-1:0];
            step_lower = {lower[W-2:0], 1'b1};
        end else begin
            step_upper = shifted[W-1:0];
            step_lower = {lower[W-2:0], 1'b0};
        end
    end

    always_comb begin
        prod     = {step_upper, step_lower};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        res_hi   = prod_fix[2*W-1:W];
        res_lo   = prod_fix[W-1:0];
        if (is_div) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = neg_a ? -step_upper : step_upper;
                res_lo = (neg_a ^ neg_b) ? -step_lower : step_lower;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            upper <= '0;
            lower <= '0;
            count <= '0;
        end else if (accept) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            upper <= '0;
            lower <= op[1] ? magnitude(a, ~op[0]) : magnitude(b, ~op[0]);
            count <= '0;
        end else if (state == RUN) begin
            upper <= step_upper;
            lower <= step_lower;
            count <= count + 1'b1;
        end
    end

    // Software writes are only honoured while idle; a result always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
